// File: rtl/uart_rxfifo.sv
// uart_rxfifo: receive-side first-word-fall-through FIFO between uart_rx and the
// UART status/data registers. Each entry holds {perr, ferr, byte}. Error pulses
// seen before a byte arrives are held as pending tags and attached to that byte.
module uart_rxfifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int THRESHOLD  = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [7:0]            rx_byte_i,
  input  logic                  rx_en_i,
  input  logic                  frame_err_i,
  input  logic                  parity_err_i,
  input  logic                  rd_en_i,
  output logic [7:0]            rd_data_o,
  output logic                  rd_ferr_o,
  output logic                  rd_perr_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  thr_o,
  output logic                  overflow_o,
  input  logic                  clear_ovf_i,
  input  logic                  flush_i
);

  localparam int                    DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_THR  = (DEPTH_LOG2 + 1)'(THRESHOLD);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [9:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_pend_ferr;
  logic                  r_pend_perr;
  logic                  r_ovf;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [9:0]            w_entry;
  logic [9:0]            w_head;

  // Status decode from the registered level; a separate level counter keeps
  // full and empty distinct even though both pointers wrap to the same value.
  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LVL_FULL);

  // A pop on an empty FIFO is ignored; a push into a full FIFO is still
  // accepted when a real pop frees a slot in the same cycle.
  assign w_pop  = rd_en_i & ~w_empty;
  assign w_push = rx_en_i & (~w_full | w_pop);
  assign w_drop = rx_en_i & w_full & ~w_pop;

  // Error pulses coincident with the strobe belong to the byte being pushed.
  assign w_entry = {r_pend_perr | parity_err_i, r_pend_ferr | frame_err_i, rx_byte_i};
  assign w_head  = r_mem[r_rd_ptr];

  assign empty_o    = w_empty;
  assign full_o     = w_full;
  assign thr_o      = (r_level >= LVL_THR);
  assign level_o    = r_level;
  assign overflow_o = r_ovf;

  // Head outputs fall through from the array, forced to zero while empty.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    rd_data_o = '0;
    rd_ferr_o = 1'b0;
    rd_perr_o = 1'b0;
    if (!w_empty) begin
      rd_data_o = w_head[7:0];
      rd_ferr_o = w_head[8];
      rd_perr_o = w_head[9];
    end
  end

  // Entry storage: written on an accepted push, never cleared.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; level and pointers alone decide which
    // entries are valid, so clearing the storage would only cost logic.
    if (resetn && !flush_i && w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  // Pointers and level: flush wins over push/pop, then both act together.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!resetn || flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push && !w_pop)      r_level <= r_level + LVL_ONE;
      else if (w_pop && !w_push) r_level <= r_level - LVL_ONE;
    end
  end

  // Pending error tags: collected between strobes, consumed by any strobe.
  always_ff @(posedge clk) begin
    if (!resetn || flush_i) begin
      r_pend_ferr <= 1'b0;
      r_pend_perr <= 1'b0;
    end else if (rx_en_i) begin
      r_pend_ferr <= 1'b0;
      r_pend_perr <= 1'b0;
    end else begin
      r_pend_ferr <= r_pend_ferr | frame_err_i;
      r_pend_perr <= r_pend_perr | parity_err_i;
    end
  end

  // Sticky overflow: a dropped byte sets it and beats a simultaneous clear;
  // a flush leaves it untouched.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ovf <= 1'b0;
    end else if (!flush_i) begin
      if (w_drop)           r_ovf <= 1'b1;
      else if (clear_ovf_i) r_ovf <= 1'b0;
    end
  end

endmodule
